trx_input_arbiter: RTL

//  Round-robin arbiter sharing one transceiver input between REQ_NUM input FIFOs (4 mesh ports + local).

---
 rtl/trx_input_arbiter_pkg.sv | 30 +++
 rtl/trx_input_arbiter_if.sv | 55 +++++
 rtl/trx_input_arbiter_rr_picker.sv | 31 +++
 rtl/trx_input_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/trx_input_arbiter_pkg.sv
// Shared types and helpers for the transceiver input arbiter: flit layout and FSM encoding.
package trx_input_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Flit layout, LSB first: payload, address, then one flag bit at the top.
  function automatic int bus_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  function automatic int flit_data_lsb();
    return 0;
  endfunction

  function automatic int flit_addr_lsb(input int data_size);
    return data_size;
  endfunction

  function automatic int flit_flag_bit(input int data_size, input int addr_size);
    return data_size + addr_size;
  endfunction

  function automatic int idx_width(input int req_num);
    return (req_num > 1) ? $clog2(req_num) : 1;
  endfunction

endpackage

// File: rtl/trx_input_arbiter_if.sv
// Bundle between router input FIFOs, the arbiter and the transceiver.
// The timeout pulse exists only when ARB_TIMEOUT_EN is defined.
interface trx_input_arbiter_if
  import trx_input_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int ADDR_SIZE = 1,
  parameter int REQ_NUM   = 5
) ();

  localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE);

  // Handshake: a flit moves on a rising clk edge where the reader's r_req is
  // high and the matching empty flag is low; r_req against an empty FIFO is a no-op.
  logic [REQ_NUM-1:0]          fifo_empty;
  logic [BUS_SIZE*REQ_NUM-1:0] fifo_data;
  logic [REQ_NUM-1:0]          fifo_r_req;
  logic                        trx_r_req;
  logic                        trx_empty;
  logic [BUS_SIZE-1:0]         trx_data;
  logic [REQ_NUM-1:0]          gnt;
  logic                        busy;
`ifdef ARB_TIMEOUT_EN
  logic                        timeout;
`endif

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  trx_r_req,
    output fifo_r_req,
    output trx_empty,
    output trx_data,
    output gnt,
`ifdef ARB_TIMEOUT_EN
    output timeout,
`endif
    output busy
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output trx_r_req,
    input  fifo_r_req,
    input  trx_empty,
    input  trx_data,
    input  gnt,
`ifdef ARB_TIMEOUT_EN
    input  timeout,
`endif
    input  busy
  );

endinterface

// File: rtl/trx_input_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after i_last_idx, wrapping around.
module trx_input_arbiter_rr_picker #(
  parameter int REQ_NUM = 5,
  parameter int IDX_W   = 3
) (
  input  logic [REQ_NUM-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_idx,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx,
  output logic [REQ_NUM-1:0] o_onehot
);

  logic [IDX_W-1:0] w_cand;

  // The previous owner is the last candidate tried, which gives the fairness order.
  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_cand   = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      w_cand = IDX_W'((int'(i_last_idx) + k) % REQ_NUM);
      if (!o_found && i_req[w_cand]) begin
        o_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trx_input_arbiter.sv
// Round-robin arbiter sharing one transceiver input among REQ_NUM FIFOs with bursts of BURST_LEN.
// ARB_TIMEOUT_EN adds a stall counter that force-releases a grant and pulses bus.timeout.
module trx_input_arbiter
  import trx_input_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int ADDR_SIZE = 1,
  parameter int REQ_NUM   = 5,
  parameter int BURST_LEN = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input  logic                 clk,
  input  logic                 a_rst,
  trx_input_arbiter_if.master  bus,
  output arb_state_e           o_state
);

  localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE);
  localparam int IDX_W    = idx_width(REQ_NUM);
  localparam int CNT_W    = $clog2(BURST_LEN + 1);
`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W  = $clog2(TIMEOUT + 1);
`endif

  arb_state_e          r_state, w_state_nxt;
  logic [REQ_NUM-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [IDX_W-1:0]    r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0]    r_burst_cnt, w_burst_cnt_nxt;
`ifdef ARB_TIMEOUT_EN
  logic [STALL_W-1:0]  r_stall_cnt, w_stall_cnt_nxt;
  logic                r_timeout;
`endif
  logic                w_force;

  logic                w_found;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [REQ_NUM-1:0]  w_pick_onehot;

  logic                w_active;
  logic                w_cur_empty;
  logic [BUS_SIZE-1:0] w_cur_data;
  logic                w_consume;

  trx_input_arbiter_rr_picker #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req      (~bus.fifo_empty),
    .i_last_idx (r_last_idx),
    .o_found    (w_found),
    .o_idx      (w_pick_idx),
    .o_onehot   (w_pick_onehot)
  );

  // Reset masks the datapath in the same cycle so a mid-burst reset consumes nothing.
  assign w_active    = (r_state == ST_BUSY) && !a_rst;
  assign w_cur_empty = bus.fifo_empty[r_idx];
  assign w_cur_data  = bus.fifo_data[r_idx*BUS_SIZE +: BUS_SIZE];
  assign w_consume   = w_active && bus.trx_r_req && !w_cur_empty;

  always_comb begin
    bus.trx_empty  = 1'b1;
    bus.trx_data   = '0;
    bus.fifo_r_req = '0;
    if (w_active) begin
      bus.trx_empty  = w_cur_empty;
      bus.trx_data   = w_cur_data;
      bus.fifo_r_req = r_gnt & {REQ_NUM{bus.trx_r_req}};
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.busy = (r_state == ST_BUSY);
  assign o_state  = r_state;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = r_timeout;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_idx_nxt       = r_idx;
    w_last_idx_nxt  = r_last_idx;
    w_burst_cnt_nxt = r_burst_cnt;
`ifdef ARB_TIMEOUT_EN
    w_stall_cnt_nxt = r_stall_cnt;
`endif
    w_force         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_BUSY;
          w_gnt_nxt       = w_pick_onehot;
          w_idx_nxt       = w_pick_idx;
          w_burst_cnt_nxt = '0;
`ifdef ARB_TIMEOUT_EN
          w_stall_cnt_nxt = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
        // Only a live flit with no reader counts as a stall.
        if (w_consume) begin
          w_stall_cnt_nxt = '0;
        end else if (!w_cur_empty && !bus.trx_r_req) begin
          if (r_stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            w_force = 1'b1;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
          end
        end
`endif
        if ((w_consume && (r_burst_cnt == CNT_W'(BURST_LEN - 1))) || w_cur_empty || w_force) begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = '0;
          w_last_idx_nxt  = r_idx;
          w_burst_cnt_nxt = '0;
        end else if (w_consume) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_idx       <= '0;
      r_last_idx  <= IDX_W'(REQ_NUM - 1);
      r_burst_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_idx       <= w_idx_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
`ifdef ARB_TIMEOUT_EN
      r_stall_cnt <= w_stall_cnt_nxt;
      r_timeout   <= w_force;
`endif
    end
  end

endmodule
